// File: rtl/ble_arb_pkg.sv
// Shared types and constants for the BLE PHY shared-buffer memory arbiter.
package ble_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PHY_LOCK  = 2'd1,
    AHB_FORCE = 2'd2
  } arb_state_e;

  localparam logic OWN_AHB = 1'b0;
  localparam logic OWN_PHY = 1'b1;

endpackage

// File: rtl/ble_arb_starve_cnt.sv
// Saturating count of consecutive cycles in which an AHB request was denied.
// o_at_max looks at the value the counter holds after this cycle's update.
module ble_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_inc,
  input  logic i_clr,
  input  logic i_freeze,
  output logic o_at_max
);

  localparam int              CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)
      w_cnt_nxt = '0;
    else if (!i_freeze && i_inc && (r_cnt != MAX_C))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

  assign o_at_max = (w_cnt_nxt == MAX_C);

endmodule

// File: rtl/ble_mem_arbiter.sv
// Two-requester (PHY over AHB) arbiter and 2-stage sequencer for the BLE PHY
// shared buffer memory. Define BLE_ARB_STARVE_GUARD_EN to add the AHB starvation guard.
module ble_mem_arbiter
  import ble_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          ahb_req,
  input  logic          ahb_we,
  input  logic [AW-1:0] ahb_addr,
  input  logic [DW-1:0] ahb_wdata,
  output logic          ahb_gnt,
  output logic          ahb_rvalid,
  output logic [DW-1:0] ahb_rdata,
  input  logic          phy_req,
  input  logic          phy_we,
  input  logic          phy_lock,
  input  logic [AW-1:0] phy_addr,
  input  logic [DW-1:0] phy_wdata,
  output logic          phy_gnt,
  output logic          phy_rvalid,
  output logic [DW-1:0] phy_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          w_ahb_gnt;
  logic          w_phy_gnt;
  logic          w_at_max;

  logic          r_mem_re;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_tag;
  logic          r_rd_pend;
  logic          r_rd_tag;

`ifdef BLE_ARB_STARVE_GUARD_EN
  logic w_cnt_inc;
  logic w_cnt_clr;
  logic w_cnt_frz;

  assign w_cnt_inc = ahb_req & ~w_ahb_gnt;
  assign w_cnt_clr = w_ahb_gnt;
  assign w_cnt_frz = (r_state == PHY_LOCK);

  ble_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .i_inc    (w_cnt_inc),
    .i_clr    (w_cnt_clr),
    .i_freeze (w_cnt_frz),
    .o_at_max (w_at_max)
  );
`else
  // Strict PHY priority: AHB is never forced, whatever MAX_WAIT says.
  assign w_at_max = (MAX_WAIT < 0);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_state <= IDLE;
    else
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_at_max)
          w_state_nxt = AHB_FORCE;
        else if (w_phy_gnt && phy_lock)
          w_state_nxt = PHY_LOCK;
      end
      PHY_LOCK: begin
        if (!phy_lock)
          w_state_nxt = IDLE;
      end
      AHB_FORCE: begin
        // A lock requested alongside the forced AHB slot applies afterwards.
        w_state_nxt = (w_phy_gnt && phy_lock) ? PHY_LOCK : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ahb_gnt = 1'b0;
    w_phy_gnt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_phy_gnt = phy_req;
        w_ahb_gnt = ahb_req & ~phy_req;
      end
      PHY_LOCK: begin
        w_phy_gnt = phy_req;
        w_ahb_gnt = ahb_req & ~phy_req & ~phy_lock;
      end
      AHB_FORCE: begin
        w_ahb_gnt = ahb_req;
        w_phy_gnt = phy_req & ~ahb_req;
      end
      default: ;
    endcase
    // NOTE: grants are combinational, so reset must gate them to force outputs low at once.
    if (!HRESETn) begin
      w_ahb_gnt = 1'b0;
      w_phy_gnt = 1'b0;
    end
  end

  // Stage 1 registers the memory command; stage 2 delays the read owner to
  // line up with mem_rdata.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag       <= OWN_AHB;
      r_rd_pend   <= 1'b0;
      r_rd_tag    <= OWN_AHB;
    end else begin
      r_mem_re <= w_phy_gnt ? ~phy_we : (w_ahb_gnt & ~ahb_we);
      r_mem_we <= w_phy_gnt ?  phy_we : (w_ahb_gnt &  ahb_we);
      if (w_phy_gnt) begin
        r_mem_addr  <= phy_addr;
        r_mem_wdata <= phy_wdata;
        r_tag       <= OWN_PHY;
      end else if (w_ahb_gnt) begin
        r_mem_addr  <= ahb_addr;
        r_mem_wdata <= ahb_wdata;
        r_tag       <= OWN_AHB;
      end
      r_rd_pend <= r_mem_re;
      r_rd_tag  <= r_tag;
    end
  end

  assign ahb_gnt    = w_ahb_gnt;
  assign phy_gnt    = w_phy_gnt;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign ahb_rvalid = r_rd_pend & (r_rd_tag == OWN_AHB);
  assign phy_rvalid = r_rd_pend & (r_rd_tag == OWN_PHY);
  assign ahb_rdata  = ahb_rvalid ? mem_rdata : '0;
  assign phy_rdata  = phy_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_ble_mem_arbiter.sv
// Directed bench for ble_mem_arbiter: vector table plus contention, lock-burst
// and reset sequences. Expectations follow BLE_ARB_STARVE_GUARD_EN when defined.
module tb_ble_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

`ifdef BLE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam bit          H   = 1'b1;
  localparam bit          L   = 1'b0;
  localparam logic [9:0]  Z10 = 10'h000;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [31:0] DA  = 32'hA5A5_0001;
  localparam logic [31:0] DP  = 32'h5A5A_0011;
  localparam logic [31:0] D10 = 32'hC0DE_0010;
  localparam logic [31:0] D11 = 32'hC0DE_0011;
  localparam logic [31:0] D20 = 32'hC0DE_0020;
  localparam logic [31:0] D30 = 32'hC0DE_0030;
  localparam logic [31:0] D40 = 32'hC0DE_0040;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          ahb_req = 1'b0, ahb_we = 1'b0;
  logic [AW-1:0] ahb_addr = '0;
  logic [DW-1:0] ahb_wdata = '0;
  logic          ahb_gnt, ahb_rvalid;
  logic [DW-1:0] ahb_rdata;
  logic          phy_req = 1'b0, phy_we = 1'b0, phy_lock = 1'b0;
  logic [AW-1:0] phy_addr = '0;
  logic [DW-1:0] phy_wdata = '0;
  logic          phy_gnt, phy_rvalid;
  logic [DW-1:0] phy_rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ble_mem_arbiter dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .ahb_req    (ahb_req),
    .ahb_we     (ahb_we),
    .ahb_addr   (ahb_addr),
    .ahb_wdata  (ahb_wdata),
    .ahb_gnt    (ahb_gnt),
    .ahb_rvalid (ahb_rvalid),
    .ahb_rdata  (ahb_rdata),
    .phy_req    (phy_req),
    .phy_we     (phy_we),
    .phy_lock   (phy_lock),
    .phy_addr   (phy_addr),
    .phy_wdata  (phy_wdata),
    .phy_gnt    (phy_gnt),
    .phy_rvalid (phy_rvalid),
    .phy_rdata  (phy_rdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: unwritten words read as 0xC0DE_0000 | address.
  logic [DW-1:0] wr_mem [1<<AW];
  bit            wr_vld [1<<AW];

  always @(posedge HCLK) begin
    if (mem_we) begin
      wr_mem[mem_addr] <= mem_wdata;
      wr_vld[mem_addr] <= 1'b1;
    end
    if (mem_re)
      mem_rdata <= wr_vld[mem_addr] ? wr_mem[mem_addr] : (32'hC0DE_0000 | 32'(mem_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    bit          a_req, a_we;
    logic [9:0]  a_addr;
    logic [31:0] a_wd;
    bit          p_req, p_we, p_lock;
    logic [9:0]  p_addr;
    logic [31:0] p_wd;
    bit          e_agnt, e_pgnt, e_mre, e_mwe, e_arv, e_prv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t row(
    input bit ar, input bit aw, input logic [9:0] aa, input logic [31:0] ad,
    input bit pr, input bit pw, input bit pl, input logic [9:0] pa, input logic [31:0] pd,
    input bit eag, input bit epg, input bit emr, input bit emw,
    input bit ear, input bit epr, input logic [31:0] ed);
    vec_t v;
    v.a_req = ar;  v.a_we = aw;  v.a_addr = aa;  v.a_wd = ad;
    v.p_req = pr;  v.p_we = pw;  v.p_lock = pl;  v.p_addr = pa;  v.p_wd = pd;
    v.e_agnt = eag; v.e_pgnt = epg; v.e_mre = emr; v.e_mwe = emw;
    v.e_arv = ear;  v.e_prv = epr;  v.e_rd = ed;
    return v;
  endfunction

  // Expected read responses for the two cycles in flight ([1] is due now).
  bit          hv   [2];
  bit          hown [2];
  logic [31:0] hd   [2];

  task automatic step(input string tag, input bit e_agnt, input bit e_pgnt,
                      input bit e_read, input bit e_own, input logic [31:0] e_data);
    @(negedge HCLK);
    check1({tag, " ahb_gnt"},    ahb_gnt,    e_agnt);
    check1({tag, " phy_gnt"},    phy_gnt,    e_pgnt);
    check1({tag, " ahb_rvalid"}, ahb_rvalid, hv[1] && !hown[1]);
    check1({tag, " phy_rvalid"}, phy_rvalid, hv[1] &&  hown[1]);
    if (hv[1] && hown[1]) check({tag, " phy_rdata"}, phy_rdata, hd[1]);
    if (hv[1] && !hown[1]) check({tag, " ahb_rdata"}, ahb_rdata, hd[1]);
    hv[1] = hv[0];  hown[1] = hown[0];  hd[1] = hd[0];
    hv[0] = e_read; hown[0] = e_own;    hd[0] = e_data;
    @(posedge HCLK); #1;
  endtask

  vec_t tbl [15];

  initial begin
    tbl[0]  = row(H,H,10'h004,DA,  L,L,L,Z10,Z32,     H,L,L,L,L,L,Z32);
    tbl[1]  = row(H,L,10'h004,Z32, L,L,L,Z10,Z32,     H,L,L,H,L,L,Z32);
    tbl[2]  = row(L,L,Z10,Z32,     L,L,L,Z10,Z32,     L,L,H,L,L,L,Z32);
    tbl[3]  = row(L,L,Z10,Z32,     L,L,L,Z10,Z32,     L,L,L,L,H,L,DA);
    tbl[4]  = row(H,L,10'h010,Z32, L,L,L,Z10,Z32,     H,L,L,L,L,L,Z32);
    tbl[5]  = row(L,L,Z10,Z32,     H,L,L,10'h011,Z32, L,H,H,L,L,L,Z32);
    tbl[6]  = row(H,L,10'h010,Z32, L,L,L,Z10,Z32,     H,L,H,L,H,L,D10);
    tbl[7]  = row(L,L,Z10,Z32,     H,L,L,10'h011,Z32, L,H,H,L,L,H,D11);
    tbl[8]  = row(L,L,Z10,Z32,     L,L,L,Z10,Z32,     L,L,H,L,H,L,D10);
    tbl[9]  = row(L,L,Z10,Z32,     L,L,L,Z10,Z32,     L,L,L,L,L,H,D11);
    tbl[10] = row(L,L,Z10,Z32,     H,H,L,10'h011,DP,  L,H,L,L,L,L,Z32);
    tbl[11] = row(L,L,Z10,Z32,     L,L,L,Z10,Z32,     L,L,L,H,L,L,Z32);
    tbl[12] = row(L,L,Z10,Z32,     H,L,L,10'h011,Z32, L,H,L,L,L,L,Z32);
    tbl[13] = row(L,L,Z10,Z32,     L,L,L,Z10,Z32,     L,L,H,L,L,L,Z32);
    tbl[14] = row(L,L,Z10,Z32,     L,L,L,Z10,Z32,     L,L,L,L,L,H,DP);

    // Reset state.
    repeat (2) @(posedge HCLK);
    #1;
    check1("reset ahb_gnt",    ahb_gnt,    1'b0);
    check1("reset phy_gnt",    phy_gnt,    1'b0);
    check1("reset mem_re",     mem_re,     1'b0);
    check1("reset mem_we",     mem_we,     1'b0);
    check1("reset ahb_rvalid", ahb_rvalid, 1'b0);
    check1("reset phy_rvalid", phy_rvalid, 1'b0);
    HRESETn = 1'b1;

    // Vector table: single-owner writes/reads and alternating owners.
    for (int i = 0; i < 15; i++) begin
      string t;
      ahb_req = tbl[i].a_req;  ahb_we = tbl[i].a_we;  ahb_addr = tbl[i].a_addr;
      ahb_wdata = tbl[i].a_wd;
      phy_req = tbl[i].p_req;  phy_we = tbl[i].p_we;  phy_lock = tbl[i].p_lock;
      phy_addr = tbl[i].p_addr; phy_wdata = tbl[i].p_wd;
      @(negedge HCLK);
      t = $sformatf("vec%0d", i);
      check1({t, " ahb_gnt"},    ahb_gnt,    tbl[i].e_agnt);
      check1({t, " phy_gnt"},    phy_gnt,    tbl[i].e_pgnt);
      check1({t, " mem_re"},     mem_re,     tbl[i].e_mre);
      check1({t, " mem_we"},     mem_we,     tbl[i].e_mwe);
      check1({t, " ahb_rvalid"}, ahb_rvalid, tbl[i].e_arv);
      check1({t, " phy_rvalid"}, phy_rvalid, tbl[i].e_prv);
      if (tbl[i].e_arv) check({t, " ahb_rdata"}, ahb_rdata, tbl[i].e_rd);
      if (tbl[i].e_prv) check({t, " phy_rdata"}, phy_rdata, tbl[i].e_rd);
      @(posedge HCLK); #1;
    end

    // Both owners read every cycle for 20 cycles.
    ahb_req = 1'b1; ahb_we = 1'b0; ahb_addr = 10'h020;
    phy_req = 1'b1; phy_we = 1'b0; phy_lock = 1'b0; phy_addr = 10'h030;
    for (int i = 0; i < 20; i++) begin
      bit a;
      a = GUARD && ((i % 5) == 4);
      step($sformatf("cont%0d", i), a, !a, 1'b1, !a, a ? D20 : D30);
    end
    phy_req = 1'b0;
    step("cont_release", 1'b1, 1'b0, 1'b1, 1'b0, D20);
    ahb_req = 1'b0;
    step("cont_drain0", 1'b0, 1'b0, 1'b0, 1'b0, Z32);
    step("cont_drain1", 1'b0, 1'b0, 1'b0, 1'b0, Z32);

    // Locked PHY burst of 6 reads with AHB waiting throughout.
    ahb_req = 1'b1; ahb_addr = 10'h040;
    phy_req = 1'b1; phy_lock = 1'b1;
    for (int k = 0; k < 6; k++) begin
      phy_addr = 10'h050 + 10'(k);
      step($sformatf("lock%0d", k), 1'b0, 1'b1, 1'b1, 1'b1, 32'hC0DE_0050 + 32'(k));
    end
    phy_req = 1'b0; phy_lock = 1'b0;
    step("unlock", 1'b1, 1'b0, 1'b1, 1'b0, D40);
    ahb_req = 1'b0;
    step("lock_drain0", 1'b0, 1'b0, 1'b0, 1'b0, Z32);
    step("lock_drain1", 1'b0, 1'b0, 1'b0, 1'b0, Z32);

    // Async reset one cycle after a locked PHY read grant.
    phy_req = 1'b1; phy_we = 1'b0; phy_lock = 1'b1; phy_addr = 10'h055;
    @(negedge HCLK);
    check1("rst_seq phy_gnt", phy_gnt, 1'b1);
    @(posedge HCLK); #1;
    phy_req = 1'b0; ahb_req = 1'b1; ahb_we = 1'b0; ahb_addr = 10'h010;
    #1;
    check1("rst_seq pre mem_re", mem_re, 1'b1);
    check1("rst_seq locked ahb_gnt", ahb_gnt, 1'b0);
    HRESETn = 1'b0;
    #1;
    check1("rst_in ahb_gnt",    ahb_gnt,    1'b0);
    check1("rst_in phy_gnt",    phy_gnt,    1'b0);
    check1("rst_in mem_re",     mem_re,     1'b0);
    check1("rst_in mem_we",     mem_we,     1'b0);
    check("rst_in mem_addr",    {22'd0, mem_addr}, Z32);
    check("rst_in mem_wdata",   mem_wdata,  Z32);
    check1("rst_in ahb_rvalid", ahb_rvalid, 1'b0);
    check1("rst_in phy_rvalid", phy_rvalid, 1'b0);
    check("rst_in ahb_rdata",   ahb_rdata,  Z32);
    check("rst_in phy_rdata",   phy_rdata,  Z32);
    @(posedge HCLK);
    @(negedge HCLK);
    check1("rst_hold phy_rvalid", phy_rvalid, 1'b0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check1("post_rst ahb_gnt",    ahb_gnt,    1'b1);
    check1("post_rst phy_rvalid", phy_rvalid, 1'b0);
    check1("post_rst ahb_rvalid", ahb_rvalid, 1'b0);
    @(posedge HCLK); #1;
    ahb_req = 1'b0; phy_lock = 1'b0;
    @(negedge HCLK);
    check1("post_rst1 phy_rvalid", phy_rvalid, 1'b0);
    check1("post_rst1 ahb_rvalid", ahb_rvalid, 1'b0);
    @(posedge HCLK);
    @(negedge HCLK);
    check1("post_rst2 ahb_rvalid", ahb_rvalid, 1'b1);
    check("post_rst2 ahb_rdata",   ahb_rdata,  D10);
    check1("post_rst2 phy_rvalid", phy_rvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ble_mem_arbiter.md
# ble_mem_arbiter

Single-port arbiter and sequencer for the BLE PHY shared buffer memory, the region that sits above the register file in the PHY address map. Two requesters share it: the AHB slave path (CPU reads and writes) and the PHY baseband engine (TX payload fetch, RX payload store). The block arbitrates per cycle, pipelines the memory command, and routes read data back to the requester that issued it. PHY traffic has priority, with an optional starvation guard for AHB and a lock for packet-length PHY bursts.

## Interface
- AW, 10, memory word-address width (already offset-corrected, decoding bits removed)
- DW, 32, data width
- MAX_WAIT, 4, consecutive denied AHB cycles before AHB is forced; must be >= 1
- HCLK  input  1  clock, all logic on rising edge
- HRESETn  input  1  reset, asynchronous, active-low
- ahb_req / ahb_we  input  1 / 1  AHB access request; 1 = write
- ahb_addr / ahb_wdata  input  AW / DW  AHB address / write data
- ahb_gnt  output  1  one-cycle grant pulse
- ahb_rvalid / ahb_rdata  output  1 / DW  AHB read response
- phy_req / phy_we / phy_lock  input  1 / 1 / 1  PHY request, write, burst lock
- phy_addr / phy_wdata  input  AW / DW  PHY address / write data
- phy_gnt  output  1  one-cycle grant pulse
- phy_rvalid / phy_rdata  output  1 / DW  PHY read response
- mem_re / mem_we  output  1 / 1  memory strobes, registered
- mem_addr / mem_wdata  output  AW / DW  memory command, registered
- mem_rdata  input  DW  synchronous-read data, valid 1 cycle after mem_re

## Operation
- Request rule: req, we, addr, and wdata are held stable until the matching gnt. A grant consumes exactly one request. The requester may present its next request in the following cycle.
- FSM states:
  - IDLE: normal arbitration.
  - PHY_LOCK: entered when phy_gnt is issued with phy_lock=1. In this state AHB is never granted. Returns to IDLE on the first cycle phy_lock=0.
  - AHB_FORCE: entered when the wait counter reaches MAX_WAIT. Grants AHB, then returns to IDLE.
- IDLE arbitration: phy_req wins over ahb_req. AHB is granted only when phy_req=0.
- Wait counter: width $clog2(MAX_WAIT+1), saturating.
  - Increments each cycle ahb_req=1 and ahb_gnt=0.
  - Clears on ahb_gnt.
  - Frozen in PHY_LOCK.
- Read tag: a 1-bit owner tag (0 = AHB, 1 = PHY) is registered with each read. A 1-cycle-late copy of the tag steers mem_rdata to the correct rdata/rvalid pair.
- Only one mem_re or mem_we is asserted per cycle. Writes produce no response.
- Reset: every output is 0, state is IDLE, counter is 0, tags are cleared. Reset mid-access drops the pending rvalid; no response is produced after reset release.

## Timing
- Cycle N: req sampled; gnt asserted combinationally in N.
- Cycle N+1: mem_re/mem_we, mem_addr, and mem_wdata driven from registers.
- Cycle N+2: rvalid=1 for one cycle, rdata = mem_rdata. Read latency is 2 cycles from grant.
- Throughput: one access per cycle. Back-to-back grants, including alternating owners, are legal and overlap in the pipeline.
- Simultaneous requests in IDLE with counter < MAX_WAIT: PHY is granted and the counter increments.
- Simultaneous requests with counter == MAX_WAIT and no lock: AHB is granted and PHY waits.
- phy_lock asserted together with a forced AHB cycle: AHB_FORCE completes first, then the lock applies.
- rvalid is held 0 in all other cycles. rdata is don't-care when rvalid=0.

## Configuration
- BLE_ARB_STARVE_GUARD_EN:
  - Defined: wait counter and AHB_FORCE are implemented as described above.
  - Undefined: no counter and no AHB_FORCE state. PHY has strict priority, so AHB can wait indefinitely while phy_req=1. MAX_WAIT is ignored.

## Structure
- Package ble_arb_pkg:
  - FSM state encoding (IDLE, PHY_LOCK, AHB_FORCE).
  - Owner tag constants OWN_AHB=0, OWN_PHY=1.
  - Default AW/DW constants.
- Sub-module ble_arb_starve_cnt: saturating wait counter with inc, clr, and freeze inputs and an at_max output. Instantiated only under BLE_ARB_STARVE_GUARD_EN.

## Test plan
- AHB alone writes 0xA5A5_0001 to addr 0x004, then reads 0x004 → ahb_gnt in N and N+1; mem_we at N+1; ahb_rvalid at N+3 with rdata 0xA5A5_0001.
- Both request reads every cycle, MAX_WAIT=4, guard on → PHY granted 4 times, then AHB once, pattern repeats; every rvalid routed to the correct owner.
- Guard off, same stimulus for 20 cycles → ahb_gnt never asserted; after phy_req drops, AHB is granted the next cycle.
- PHY lock burst of 6 reads with ahb_req high throughout → no ahb_gnt during the lock; AHB granted in the first cycle phy_lock=0.
- Alternating AHB read 0x010 / PHY read 0x011 → each rvalid appears 2 cycles after its grant, with matching data and no cross-routing.
- HRESETn asserted one cycle after a read grant → no rvalid; all outputs 0 immediately; state IDLE after release.
